seg_display_scanner: RTL and testbench

//   Time-multiplexed driver for a DIGITS-wide common-strobe 7-segment+DP display.

---
 rtl/seg_display_scanner.sv | 83 ++++++++
 tb/tb_seg_display_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a DIGITS-wide common-strobe 7-segment+DP display.
// Scans one digit per DIV-cycle slot, blanks the first BLANK cycles of each slot,
// gates the strobe with a 4-bit PWM, and latches the display inputs once per frame.
module seg_display_scanner #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 500
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [8*DIGITS-1:0]   seg_data,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     SD,
    output logic [7:0]            SEG,
    output logic                  frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [8*DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]     shadow_en_q, shadow_en_d;
    logic [DIGITS-1:0]     sd_q, sd_d;
    logic [7:0]            seg_q, seg_d;
    logic                  fs_q, fs_d;
    logic                  slot_end;
    logic                  snap;
    logic                  lit;

    // Next-state: counters with explicit wrap, frame snapshot, lit decision and output patterns
    always_comb begin
        slot_end      = (cnt_q == CNT_LAST);
        snap          = slot_end && (idx_q == IDX_LAST);
        cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        shadow_data_d = snap ? seg_data : shadow_data_q;
        shadow_en_d   = snap ? digit_en : shadow_en_q;
        fs_d          = snap;
        lit           = shadow_en_q[idx_q]
                        && (int'(cnt_q) >= BLANK)
                        && ((brightness == 4'hF) || (cnt_q[3:0] < brightness));
        sd_d          = '0;
        seg_d         = '0;
        if (lit) begin
            sd_d  = DIGITS'(1) << idx_q;
            seg_d = shadow_data_q[8*idx_q +: 8];
        end
    end

    // State and registered outputs; asynchronous active-low reset clears everything
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            sd_q          <= '0;
            seg_q         <= '0;
            fs_q          <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            sd_q          <= sd_d;
            seg_q         <= seg_d;
            fs_q          <= fs_d;
        end
    end

    assign SD          = sd_q;
    assign SEG         = seg_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed self-checking bench for seg_display_scanner (DIGITS=4, DIV=32, BLANK=4).
module tb_seg_display_scanner;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] seg_data = 32'h11_22_44_88;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  brightness = 4'd15;
    logic [3:0]  SD;
    logic [7:0]  SEG;
    logic        frame_start;

    int checks = 0;
    int failures = 0;
    int k = 0;            // rising edges since reset release
    int last_fs = -1;
    int bad_sd = 0;
    int on_cnt = 0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_en = '0;

    seg_display_scanner #(.DIGITS(4), .DIV(32), .BLANK(4)) dut (
        .Clock(Clock), .Reset(Reset), .seg_data(seg_data), .digit_en(digit_en),
        .brightness(brightness), .SD(SD), .SEG(SEG), .frame_start(frame_start)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // One clock: expected outputs derive from the slot position of the state before the edge
    task automatic tick();
        int s, cnt, idx;
        logic lit;
        logic [3:0] e_sd;
        logic [7:0] e_seg;
        logic e_fs;
        logic [3:0] cl;
        s   = k;
        cnt = s % 32;
        idx = (s / 32) % 4;
        cl  = 4'(cnt);
        lit = m_en[idx] && (cnt >= 4) && (brightness == 4'd15 || cl < brightness);
        e_sd  = lit ? 4'(1 << idx) : 4'h0;
        e_seg = lit ? m_data[8*idx +: 8] : 8'h00;
        e_fs  = ((s % 128) == 127);
        if (e_fs) begin
            m_data = seg_data;
            m_en   = digit_en;
        end
        @(posedge Clock);
        #1;
        k++;
        check("sd", 32'(SD), 32'(e_sd));
        check("seg", 32'(SEG), 32'(e_seg));
        check("fs", 32'(frame_start), 32'(e_fs));
        if (frame_start) begin
            if (last_fs >= 0) check("frame_period", 32'(k - last_fs), 32'd128);
            last_fs = k;
        end
        if (SD == 4'b0010 || SD == 4'b1000) bad_sd++;
        if (SD != 4'h0) on_cnt++;
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    initial begin
        // Reset held low for 5 clocks
        repeat (5) begin
            @(posedge Clock);
            #1;
            check("rst_sd", 32'(SD), 32'h0);
            check("rst_seg", 32'(SEG), 32'h0);
            check("rst_fs", 32'(frame_start), 32'h0);
        end
        @(negedge Clock);
        Reset = 1'b1;
        k = 0;

        // Frame 1 dark, snapshot pulse at edge 128
        on_cnt = 0;
        run_to(127);
        check("frame1_dark", 32'(on_cnt), 32'd0);
        run_to(128);
        check("fs_at_128", 32'(frame_start), 32'h1);
        run_to(132);
        check("blank_slot0", 32'(SD), 32'h0);
        run_to(133);
        check("slot0_sd", 32'(SD), 32'h1);
        check("slot0_seg", 32'(SEG), 32'h88);
        run_to(160);
        check("slot0_last", 32'(SD), 32'h1);
        run_to(161);
        check("slot1_blank", 32'(SD), 32'h0);
        run_to(165);
        check("slot1_sd", 32'(SD), 32'h2);
        check("slot1_seg", 32'(SEG), 32'h44);

        // Mid-frame data change stays invisible until next snapshot
        run_to(170);
        seg_data = 32'hFF_FF_FF_FF;
        run_to(200);
        check("slot2_sd", 32'(SD), 32'h4);
        check("slot2_seg_old", 32'(SEG), 32'h22);
        run_to(250);
        check("slot3_seg_old", 32'(SEG), 32'h11);
        run_to(261);
        check("new_frame_seg", 32'(SEG), 32'hFF);

        // Enable mask 0101 from frame 4
        digit_en = 4'b0101;
        run_to(384);
        bad_sd = 0;
        on_cnt = 0;
        run_to(512);
        check("masked_digits_dark", 32'(bad_sd), 32'd0);
        check("masked_on_cycles", 32'(on_cnt), 32'd56);
        check("fs_at_512", 32'(frame_start), 32'h1);

        // Brightness 0: fully dark frame
        brightness = 4'd0;
        on_cnt = 0;
        run_to(640);
        check("bright0_dark", 32'(on_cnt), 32'd0);

        // Brightness 4: slot 0 lit only at cnt 16..19
        brightness = 4'd4;
        on_cnt = 0;
        run_to(672);
        check("bright4_slot0", 32'(on_cnt), 32'd4);
        brightness = 4'd15;

        // Asynchronous reset in the middle of the idx=2 slot
        run_to(715);
        check("pre_reset_sd", 32'(SD), 32'h4);
        #2;
        Reset = 1'b0;
        #1;
        check("async_sd", 32'(SD), 32'h0);
        check("async_seg", 32'(SEG), 32'h0);
        check("async_fs", 32'(frame_start), 32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        k = 0;
        last_fs = -1;
        m_data = '0;
        m_en = '0;
        on_cnt = 0;
        run_to(127);
        check("post_reset_dark", 32'(on_cnt), 32'd0);
        run_to(128);
        check("post_reset_fs", 32'(frame_start), 32'h1);
        run_to(133);
        check("post_reset_sd", 32'(SD), 32'h1);
        check("post_reset_seg", 32'(SEG), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
